// File: rtl/cc_checker.sv
// Online golden-model checker for the CC counter: predicts each next count,
// flags deviations, counts them and captures the first one.
module cc_checker #(
    parameter int WIDTH      = 8,
    parameter int ERR_CNT_W  = 16,
    parameter int CYC_W      = 32,
    parameter int RESYNC_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fp,
    input  logic [WIDTH-1:0]     obs,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 first_err_valid,
    output logic [CYC_W-1:0]     first_err_cycle,
    output logic [WIDTH-1:0]     first_err_exp,
    output logic [WIDTH-1:0]     first_err_obs,
    output logic [CYC_W-1:0]     cycle_cnt
);

    localparam int MC_W = $clog2(RESYNC_LEN + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(RESYNC_LEN - 1);

    typedef enum logic [1:0] {
        ACQUIRE,
        LOCKED,
        RESYNC
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [MC_W-1:0]      mc_q, mc_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 fev_q, fev_d;
    logic [CYC_W-1:0]     fec_q, fec_d;
    logic [WIDTH-1:0]     fee_q, fee_d;
    logic [WIDTH-1:0]     feo_q, feo_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic [WIDTH-1:0]     obs_step;
    logic [WIDTH-1:0]     exp_step;
    logic                 mismatch;

    function automatic logic [WIDTH-1:0] step_f(
        input logic [WIDTH-1:0] v,
        input logic             en,
        input logic             up
    );
        if (!en) return v;
        return up ? v + ONE : v - ONE;
    endfunction

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        mc_d     = mc_q;
        mismatch = 1'b0;
        obs_step = step_f(obs, enable, fp);
        exp_step = step_f(exp_q, enable, fp);
        case (state_q)
            ACQUIRE: begin
                exp_d   = obs_step;
                state_d = LOCKED;
            end
            LOCKED: begin
                // A bad sample never becomes the base while locked;
                // an X sample falls into the mismatch branch.
                if (obs == exp_q) begin
                    exp_d = exp_step;
                end else begin
                    mismatch = 1'b1;
                    exp_d    = obs_step;
                    mc_d     = '0;
                    state_d  = RESYNC;
                end
            end
            RESYNC: begin
                exp_d = obs_step;
                if (obs == exp_q) begin
                    if (mc_q == MC_LAST) begin
                        mc_d    = '0;
                        state_d = LOCKED;
                    end else begin
                        mc_d = mc_q + MC_W'(1);
                    end
                end else begin
                    mismatch = 1'b1;
                    mc_d     = '0;
                end
            end
            default: state_d = ACQUIRE;
        endcase
    end

    always_comb begin
        err_pulse_d = mismatch;
        cyc_d       = cyc_q + CYC_W'(1);
        err_cnt_d   = err_cnt_q;
        fev_d       = fev_q;
        fec_d       = fec_q;
        fee_d       = fee_q;
        feo_d       = feo_q;
        // clear beats a same-cycle mismatch for count and capture
        if (clear) begin
            err_cnt_d = '0;
            fev_d     = 1'b0;
            fec_d     = '0;
            fee_d     = '0;
            feo_d     = '0;
        end else if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (!fev_q) begin
                fev_d = 1'b1;
                fec_d = cyc_q;
                fee_d = exp_q;
                feo_d = obs;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACQUIRE;
            exp_q       <= '0;
            mc_q        <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            fev_q       <= 1'b0;
            fec_q       <= '0;
            fee_q       <= '0;
            feo_q       <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            mc_q        <= mc_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            fev_q       <= fev_d;
            fec_q       <= fec_d;
            fee_q       <= fee_d;
            feo_q       <= feo_d;
            cyc_q       <= cyc_d;
        end
    end

    assign locked          = (state_q == LOCKED);
    assign err_pulse       = err_pulse_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_cycle = fec_q;
    assign first_err_exp   = fee_q;
    assign first_err_obs   = feo_q;
    assign cycle_cnt       = cyc_q;

endmodule

// File: doc/cc_checker.md
Name: cc_checker

Overview:
Online golden-model checker for the CC counter. Observes CC's enable/fp inputs and its 8-bit out bus each clk cycle. Predicts the next count and flags every deviation, so fault-injection campaigns get a hardware verdict instead of VCD post-processing. It sits beside CC in the same clock domain and drives nothing back into CC.

Parameters:
WIDTH, 8, width of the observed counter bus (CC out).
ERR_CNT_W, 16, width of the mismatch counter; saturates.
CYC_W, 32, width of the free-running cycle counter and the first-error timestamp.
RESYNC_LEN, 4, consecutive matching cycles required to return from RESYNC to LOCKED (>=1).

Ports:
clk  input  1  system clock; all logic samples on posedge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  copy of CC enable, as sampled by CC.
fp  input  1  copy of CC fp; 1 = count up, 0 = count down.
obs  input  WIDTH  CC out bus.
clear  input  1  synchronous clear of err_cnt and first-error capture; does not affect FSM or cycle_cnt.
locked  output  1  high in LOCKED state.
err_pulse  output  1  one-cycle pulse on each detected mismatch.
err_cnt  output  ERR_CNT_W  number of mismatches since reset/clear, saturating at all-ones.
first_err_valid  output  1  a first error has been captured.
first_err_cycle  output  CYC_W  cycle_cnt value at first mismatch.
first_err_exp  output  WIDTH  expected value at first mismatch.
first_err_obs  output  WIDTH  observed value at first mismatch.
cycle_cnt  output  CYC_W  posedges since reset release; wraps.

Behaviour:
- Reset values: all outputs 0. Internal exp = 0, match counter = 0, state = ACQUIRE.
- Step function: step(v) = v + 1 if enable && fp; v - 1 if enable && !fp; v if !enable. Result is modulo 2^WIDTH, so 255+1 = 0 and 0-1 = 255.
- Expected CC law: out(n+1) = step(out(n)) using enable and fp sampled at edge n.
- cycle_cnt increments every posedge while reset is low.
- FSM: three states, one transition per posedge.
  - ACQUIRE: exp <= step(obs); go to LOCKED. No comparison in this state; this absorbs CC's reset value.
  - LOCKED: compare obs with exp.
    - Match: exp <= step(exp). Use the golden exp, not obs, so a wrong value never becomes the new base.
    - Mismatch: err_pulse = 1 next cycle; err_cnt += 1 (saturating); exp <= step(obs); go to RESYNC.
  - RESYNC: compare obs with exp; exp <= step(obs) in all cases.
    - Match: match counter += 1. When it reaches RESYNC_LEN, go to LOCKED and zero the counter.
    - Mismatch: err_pulse, err_cnt += 1, match counter = 0, stay in RESYNC.
- First-error capture happens on a mismatch while first_err_valid = 0. It stores cycle_cnt of the comparing edge, exp and obs, and sets valid. Later errors do not overwrite it.
- Output latency: all outputs are registered. err_pulse and the capture fields update one edge after the compared sample. locked falls on the same edge err_pulse rises.
- clear:
  - clear zeroes err_cnt and first_err_valid (capture fields go to 0).
  - If a mismatch occurs in the same cycle as clear, clear wins for err_cnt (result 0, not 1) and the capture is not taken.
  - err_pulse still fires.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). The first compare after release happens 2 edges later (ACQUIRE, then LOCKED).
- Unknown (X) obs in LOCKED counts as a mismatch; the bench checks this in gate-level sims only.

Test Plan:
1. Reset release, enable=1, fp=1, CC counts 0..255..0 with no faults: locked=1 from the 2nd edge, err_cnt=0 across the 255->0 wrap, no err_pulse.
2. fp=0, enable=1, obs 3,2,1,0,255,254: no errors on the down-wrap.
3. enable toggling randomly for 1000 cycles with a correct model stream: err_cnt=0 and locked stays 1.
4. In LOCKED, exp=0x41, force obs=0x45 at cycle 100: err_pulse one cycle; err_cnt=1; first_err_cycle=100, exp=0x41, obs=0x45; locked=0 until 4 matching cycles, then locked=1 with the count continuing from 0x45.
5. Two faults at cycles 100 and 102 (second one inside RESYNC): err_cnt=2, capture still shows cycle 100, and the RESYNC match counter restarts.
6. clear asserted in the same cycle as a mismatch, with err_cnt=5: err_cnt=0, first_err_valid=0, err_pulse=1. Then reset asserted mid-RESYNC: all outputs 0 immediately, and relock 2 edges after release.
